// File: rtl/note_buf_pkg.sv
// note_buf_pkg -- shared types and constants for the note buffer writer.
//   nb_state_e    : writer FSM states (IDLE, FILL, WAIT_SWAP)
//   Y_W           : width of a screen row value
//   DEF_ADDR_W    : default slot address width (2**ADDR_W slots per bank)
//   DEF_Y_MAX     : default largest legal screen row
//   DEF_SPACING   : default row distance between consecutive slots
package note_buf_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      FILL      = 2'd1,
      WAIT_SWAP = 2'd2
   } nb_state_e;

   localparam int Y_W         = 8;
   localparam int DEF_ADDR_W  = 4;
   localparam int DEF_Y_MAX   = 119;
   localparam int DEF_SPACING = 8;

endpackage

// File: rtl/note_buf_writer_y_wrap_add.sv
// y_wrap_add -- modulo (Y_MAX+1) row add or subtract, combinational.
//   a_i   : row operand, assumed already in 0..Y_MAX
//   b_i   : offset, assumed in 0..Y_MAX
//   sub_i : 1 = a_i - b_i, 0 = a_i + b_i (both wrapped)
//   y_o   : wrapped result in 0..Y_MAX
// All intermediate arithmetic is 9 bits so a+b or a+MOD-b never overflows.
module y_wrap_add
   import note_buf_pkg::*;
#(
   parameter int Y_MAX = DEF_Y_MAX
) (
   input  logic [Y_W-1:0] a_i,
   input  logic [Y_W-1:0] b_i,
   input  logic           sub_i,
   output logic [Y_W-1:0] y_o
);

   localparam logic [Y_W:0] MOD_C = (Y_W+1)'(Y_MAX + 1);

   logic [Y_W:0] a_ext_s;
   logic [Y_W:0] b_ext_s;
   logic [Y_W:0] res_s;

   assign a_ext_s = {1'b0, a_i};
   assign b_ext_s = {1'b0, b_i};

   // wrapped add or subtract with a single correction step
   always_comb begin
      res_s = a_ext_s;
      if (sub_i) begin
         if (a_ext_s >= b_ext_s) begin
            res_s = a_ext_s - b_ext_s;
         end else begin
            res_s = a_ext_s + MOD_C - b_ext_s;
         end
      end else begin
         if ((a_ext_s + b_ext_s) >= MOD_C) begin
            res_s = a_ext_s + b_ext_s - MOD_C;
         end else begin
            res_s = a_ext_s + b_ext_s;
         end
      end
   end

   assign y_o = res_s[Y_W-1:0];

endmodule

// File: rtl/note_buf_writer.sv
// note_buf_writer -- fills the inactive bank of a double-buffered note RAM
// with scrolled row positions once per frame, then swaps banks on the next
// frame tick.
//   clk, resetn   : clock, asynchronous active-low reset
//   map           : scroll enable (0 freezes the base row)
//   frame_tick    : one-cycle frame start pulse
//   step          : rows scrolled per frame
//   wr_en/wr_bank/wr_addr/wr_y : RAM write port (never targets rd_bank)
//   rd_bank       : bank currently shown by the display reader
//   swap_pulse    : one-cycle strobe when rd_bank toggles
//   busy          : fill in progress
//   overrun       : one-cycle strobe when frame_tick lands during a fill
//   overrun_cnt   : saturating overrun count, present only when the macro
//                   NOTE_BUF_OVERRUN_CNT_EN is defined
module note_buf_writer
   import note_buf_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int Y_MAX   = DEF_Y_MAX,
   parameter int SPACING = DEF_SPACING
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              map,
   input  logic              frame_tick,
   input  logic [2:0]        step,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [Y_W-1:0]    wr_y,
   output logic              rd_bank,
   output logic              swap_pulse,
   output logic              busy,
`ifdef NOTE_BUF_OVERRUN_CNT_EN
   output logic [7:0]        overrun_cnt,
`endif
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] LAST_C    = {ADDR_W{1'b1}};
   localparam logic [Y_W-1:0]    SPACING_C = Y_W'(SPACING);
   localparam logic [Y_W-1:0]    Y_MAX_C   = Y_W'(Y_MAX);

   nb_state_e         state_q, state_d;
   logic [Y_W-1:0]    base_q, base_d;
   logic [Y_W-1:0]    row_q, row_d;
   logic              rd_bank_q, rd_bank_d;
   logic              wr_bank_q, wr_bank_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [Y_W-1:0]    wr_y_q, wr_y_d;
   logic              swap_q, swap_d;
   logic              overrun_q, overrun_d;

   logic [Y_W-1:0]    base_sub_s;
   logic [Y_W-1:0]    base_new_s;
   logic [Y_W-1:0]    row_next_s;

   y_wrap_add #(.Y_MAX(Y_MAX)) u_base_sub (
      .a_i   (base_q),
      .b_i   ({5'd0, step}),
      .sub_i (1'b1),
      .y_o   (base_sub_s)
   );

   y_wrap_add #(.Y_MAX(Y_MAX)) u_row_add (
      .a_i   (row_q),
      .b_i   (SPACING_C),
      .sub_i (1'b0),
      .y_o   (row_next_s)
   );

   // base moves only when scrolling is enabled
   assign base_new_s = map ? base_sub_s : base_q;

   // next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      row_d     = row_q;
      rd_bank_d = rd_bank_q;
      wr_bank_d = wr_bank_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_y_d    = wr_y_q;
      swap_d    = 1'b0;
      overrun_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (frame_tick) begin
               state_d   = FILL;
               base_d    = base_new_s;
               row_d     = base_new_s;
               wr_en_d   = 1'b1;
               wr_addr_d = '0;
               wr_y_d    = base_new_s;
            end else begin
               state_d = IDLE;
            end
         end
         FILL: begin
            // a tick here is only reported; the fill carries on untouched
            overrun_d = frame_tick;
            if (wr_addr_q == LAST_C) begin
               state_d = WAIT_SWAP;
               wr_en_d = 1'b0;
            end else begin
               wr_en_d   = 1'b1;
               wr_addr_d = wr_addr_q + ADDR_W'(1);
               wr_y_d    = row_next_s;
               row_d     = row_next_s;
            end
         end
         WAIT_SWAP: begin
            if (frame_tick) begin
               // the freshly filled bank becomes visible, the old one is refilled
               state_d   = FILL;
               rd_bank_d = ~rd_bank_q;
               wr_bank_d = rd_bank_q;
               swap_d    = 1'b1;
               base_d    = base_new_s;
               row_d     = base_new_s;
               wr_en_d   = 1'b1;
               wr_addr_d = '0;
               wr_y_d    = base_new_s;
            end else begin
               state_d = WAIT_SWAP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and output registers
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         base_q    <= Y_MAX_C;
         row_q     <= '0;
         rd_bank_q <= 1'b0;
         wr_bank_q <= 1'b1;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_y_q    <= '0;
         swap_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         row_q     <= row_d;
         rd_bank_q <= rd_bank_d;
         wr_bank_q <= wr_bank_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_y_q    <= wr_y_d;
         swap_q    <= swap_d;
         overrun_q <= overrun_d;
      end
   end

`ifdef NOTE_BUF_OVERRUN_CNT_EN
   logic [7:0] ovr_cnt_q;

   // saturating count of overrun pulses
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ovr_cnt_q <= 8'd0;
      end else if (overrun_d && (ovr_cnt_q != 8'd255)) begin
         ovr_cnt_q <= ovr_cnt_q + 8'd1;
      end else begin
         ovr_cnt_q <= ovr_cnt_q;
      end
   end

   assign overrun_cnt = ovr_cnt_q;
`endif

   assign wr_en      = wr_en_q;
   assign wr_bank    = wr_bank_q;
   assign wr_addr    = wr_addr_q;
   assign wr_y       = wr_y_q;
   assign rd_bank    = rd_bank_q;
   assign swap_pulse = swap_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q == FILL);

endmodule

// File: tb/tb_note_buf_writer.sv
// tb_note_buf_writer -- randomized self-checking bench for note_buf_writer.
// The reference model tracks base row, displayed bank and overrun count as
// plain integers and derives every slot row as (base + k*SPACING) mod rows.
// Honours NOTE_BUF_OVERRUN_CNT_EN for the optional overrun counter.
module tb_note_buf_writer;

   localparam int ADDR_W  = 4;
   localparam int Y_MAX   = 119;
   localparam int SPACING = 8;
   localparam int NROWS   = Y_MAX + 1;
   localparam int NSLOT   = 1 << ADDR_W;

   logic              clk;
   logic              resetn;
   logic              map;
   logic              frame_tick;
   logic [2:0]        step;
   logic              wr_en;
   logic              wr_bank;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_y;
   logic              rd_bank;
   logic              swap_pulse;
   logic              busy;
   logic              overrun;
`ifdef NOTE_BUF_OVERRUN_CNT_EN
   logic [7:0]        overrun_cnt;
`endif

   note_buf_writer #(.ADDR_W(ADDR_W), .Y_MAX(Y_MAX), .SPACING(SPACING)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .map         (map),
      .frame_tick  (frame_tick),
      .step        (step),
      .wr_en       (wr_en),
      .wr_bank     (wr_bank),
      .wr_addr     (wr_addr),
      .wr_y        (wr_y),
      .rd_bank     (rd_bank),
      .swap_pulse  (swap_pulse),
      .busy        (busy),
`ifdef NOTE_BUF_OVERRUN_CNT_EN
      .overrun_cnt (overrun_cnt),
`endif
      .overrun     (overrun)
   );

   int n_total;
   int n_bad;

   // reference model state
   int  base_m;
   int  rd_m;
   int  ovr_m;
   bit  idle_m;
   int  fill_y [$];
   int  prev_y [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_total++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      base_m = Y_MAX;
      rd_m   = 0;
      ovr_m  = 0;
      idle_m = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_y"}, wr_y, 0);
      check({tag, "_wr_bank"}, wr_bank, 1);
      check({tag, "_rd_bank"}, rd_bank, 0);
      check({tag, "_swap"}, swap_pulse, 0);
      check({tag, "_overrun"}, overrun, 0);
      check({tag, "_busy"}, busy, 0);
`ifdef NOTE_BUF_OVERRUN_CNT_EN
      check({tag, "_ovr_cnt"}, overrun_cnt, 0);
`endif
   endtask

   // One frame: tick, watch the whole fill, optionally tick again during
   // slot inj (overrun), optionally reset while slot rst_at is on the bus.
   task automatic do_frame(input bit mp, input int stp, input int inj, input int rst_at);
      bit exp_swap;
      int gap;
      exp_swap = !idle_m;
      if (mp) base_m = (base_m + NROWS - stp) % NROWS;
      if (exp_swap) rd_m = 1 - rd_m;
      idle_m = 1'b0;
      fill_y.delete();
      map        = mp;
      step       = 3'(stp);
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      map        = 1'($urandom);
      step       = 3'($urandom);
      check("swap_at_tick", swap_pulse, int'(exp_swap));
      for (int k = 0; k < NSLOT; k++) begin
         check("wr_en", wr_en, 1);
         check("wr_addr", wr_addr, k);
         check("wr_y", wr_y, (base_m + k * SPACING) % NROWS);
         check("wr_bank", wr_bank, 1 - rd_m);
         check("rd_bank", rd_bank, rd_m);
         check("busy", busy, 1);
         check("overrun", overrun, int'(k > 0 && inj == k - 1));
         if (k > 0) check("swap_in_fill", swap_pulse, 0);
         fill_y.push_back(int'(wr_y));
         if (k == rst_at) begin
            resetn = 1'b0;
            #1;
            check_reset_outputs("rst_mid_fill");
            model_reset();
            resetn = 1'b1;
            cyc();
            check_reset_outputs("after_rst");
            return;
         end
         frame_tick = (k == inj);
         cyc();
         frame_tick = 1'b0;
      end
      if (inj >= 0 && ovr_m < 255) ovr_m++;
      check("done_wr_en", wr_en, 0);
      check("done_busy", busy, 0);
      check("done_overrun", overrun, int'(inj == NSLOT - 1));
      check("done_swap", swap_pulse, 0);
      check("done_rd_bank", rd_bank, rd_m);
`ifdef NOTE_BUF_OVERRUN_CNT_EN
      check("ovr_cnt", overrun_cnt, ovr_m);
`endif
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
         cyc();
         check("wait_wr_en", wr_en, 0);
         check("wait_overrun", overrun, 0);
         check("wait_swap", swap_pulse, 0);
      end
   endtask

   initial begin
      n_total    = 0;
      n_bad      = 0;
      resetn     = 1'b0;
      map        = 1'b0;
      frame_tick = 1'b0;
      step       = 3'd0;
      model_reset();
      cyc();
      cyc();
      check_reset_outputs("reset");
      resetn = 1'b1;
      cyc();
      check("idle_busy", busy, 0);

      // first frame from reset: base 119 - 2 = 117, rows 117,5,13,...
      do_frame(1'b1, 2, -1, -1);
      check("first_slot1_y", fill_y[1], 5);
      // second frame: swap, base 115
      do_frame(1'b1, 2, -1, -1);
      check("second_base", fill_y[0], 115);

      // overrun on the 5th fill cycle, then on the last-write cycle
      do_frame(1'b1, 3, 4, -1);
      do_frame(1'b1, 1, NSLOT - 1, -1);

      // frozen scroll: every fill identical
      for (int f = 0; f < 3; f++) begin
         do_frame(1'b0, int'($urandom_range(0, 7)), -1, -1);
         if (f > 0) begin
            for (int k = 0; k < NSLOT; k++) check("frozen_seq", fill_y[k], prev_y[k]);
         end
         prev_y = fill_y;
      end

      // randomized frames, some with overruns, covering base wrap
      for (int f = 0; f < 40; f++) begin
         do_frame(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NSLOT - 1)) : -1, -1);
      end

      // reset on the 7th write, then a fresh fill from IDLE
      do_frame(1'b1, 5, -1, 6);
      do_frame(1'b1, 2, -1, -1);
      check("post_rst_first_y", fill_y[0], 117);
      do_frame(1'b1, 7, 2, -1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
